// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the unified memory responder:
//                FSM state encoding, initiator port identifiers, word and
//                byte-enable widths, default wait-state count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int WORD_W      = 32;
    localparam int BE_W        = 4;
    localparam int DEFAULT_LAT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // Word-aligned check on the two byte-offset bits of an address.
    function automatic logic is_misaligned(input logic [1:0] lo);
        return (lo != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port synchronous RAM, 2^ADDR_W words of WORD_W bits,
//                with per-byte write enables. Reads are registered: rdata_o
//                holds the word read on the last enabled load cycle.
//  Ports       : clk      - clock, rising edge
//                en_i     - access enable
//                we_i     - 1 = write enabled bytes, 0 = read word
//                be_i     - byte enables (bit i covers bits [8i+7:8i])
//                addr_i   - word index
//                wdata_i  - write data
//                rdata_o  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [0:DEPTH-1];
    logic [WORD_W-1:0] rdata_q;

    // Contents are intentionally not reset; a store leaves rdata_q untouched.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/unified_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_responder
//  Description : Arbitrates the instruction-fetch and data ports onto one
//                byte-enabled synchronous word array, inserts LAT wait states
//                and returns a one-cycle rvalid pulse on the served port.
//                Build option: MISALIGN_TRAP_EN - when defined, accesses with
//                addr[1:0] != 0 skip the array and respond with err=1,
//                rdata=0; when undefined addr[1:0] is ignored and err is 0.
//  Ports       : clk, rst                      - clock / sync active-high reset
//                if_req/if_addr/if_gnt         - fetch request handshake
//                if_rvalid/if_rdata/if_err     - fetch response
//                d_req/d_we/d_be/d_addr/d_wdata/d_gnt - data request handshake
//                d_rvalid/d_rdata/d_err        - data response
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_W = 10,
    parameter int unsigned LAT    = DEFAULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;
    localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    // ---------------- state ----------------
    logic [1:0]        state_q,   state_d;
    logic [3:0]        cnt_q,     cnt_d;
    port_e             last_q,    last_d;
    port_e             port_q,    port_d;
    logic [ADDR_W-1:0] idx_q,     idx_d;
    logic              we_q,      we_d;
    logic [BE_W-1:0]   be_q,      be_d;
    logic [WORD_W-1:0] wdata_q,   wdata_d;
    logic              err_q,     err_d;
    logic              if_rv_q,   if_rv_d;
    logic              d_rv_q,    d_rv_d;

    // ---------------- arbitration ----------------
    logic              w_idle;
    logic              w_pick_d;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_any_gnt;
    port_e             w_new_port;
    logic [31:0]       w_new_addr;
    logic              w_new_we;
    logic [BE_W-1:0]   w_new_be;
    logic              w_new_err;

    assign w_idle    = (state_q == S_IDLE);
    // Data wins unless fetch is alone or data was the most recent grant.
    assign w_pick_d  = d_req && (!if_req || (last_q == PORT_IF));
    assign w_if_gnt  = w_idle && !rst && if_req && !w_pick_d;
    assign w_d_gnt   = w_idle && !rst && d_req  &&  w_pick_d;
    assign w_any_gnt = w_if_gnt || w_d_gnt;

    assign w_new_port = w_d_gnt ? PORT_D : PORT_IF;
    assign w_new_addr = w_d_gnt ? d_addr : if_addr;
    assign w_new_we   = w_d_gnt && d_we;
    assign w_new_be   = w_d_gnt ? d_be : '0;

`ifdef MISALIGN_TRAP_EN
    assign w_new_err = is_misaligned(w_new_addr[1:0]);
`else
    assign w_new_err = 1'b0;
`endif

    // Upper bits alias (wrap modulo array size); the byte offset only matters
    // for the misalignment trap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_new_addr[31:ADDR_W+2], w_new_addr[1:0]};

    // ---------------- next state ----------------
    logic w_enter_resp;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        port_d       = port_q;
        idx_d        = idx_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        w_enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any_gnt) begin
                    last_d  = w_new_port;
                    port_d  = w_new_port;
                    idx_d   = w_new_addr[ADDR_W+1:2];
                    we_d    = w_new_we;
                    be_d    = w_new_be;
                    wdata_d = d_wdata;
                    err_d   = w_new_err;
                    if (LAT == 0) begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // With LAT = 0 the array access happens on the grant edge itself, so the
    // live request fields are used before they land in the capture registers.
    port_e             w_cur_port;
    logic [ADDR_W-1:0] w_cur_idx;
    logic              w_cur_we;
    logic [BE_W-1:0]   w_cur_be;
    logic [WORD_W-1:0] w_cur_wdata;
    logic              w_cur_err;

    assign w_cur_port  = w_idle ? w_new_port              : port_q;
    assign w_cur_idx   = w_idle ? w_new_addr[ADDR_W+1:2]  : idx_q;
    assign w_cur_we    = w_idle ? w_new_we                : we_q;
    assign w_cur_be    = w_idle ? w_new_be                : be_q;
    assign w_cur_wdata = w_idle ? d_wdata                 : wdata_q;
    assign w_cur_err   = w_idle ? w_new_err               : err_q;

    assign if_rv_d = w_enter_resp && (w_cur_port == PORT_IF);
    assign d_rv_d  = w_enter_resp && (w_cur_port == PORT_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= PORT_IF;
            port_q  <= PORT_IF;
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            if_rv_q <= 1'b0;
            d_rv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            port_q  <= port_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            if_rv_q <= if_rv_d;
            d_rv_q  <= d_rv_d;
        end
    end

    // ---------------- array ----------------
    logic              w_ram_en;
    logic [WORD_W-1:0] w_ram_rdata;

    // rst gates the commit so a store landing on a reset cycle is dropped.
    assign w_ram_en = w_enter_resp && !rst && !w_cur_err;

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .en_i    (w_ram_en),
        .we_i    (w_cur_we),
        .be_i    (w_cur_be),
        .addr_i  (w_cur_idx),
        .wdata_i (w_cur_wdata),
        .rdata_o (w_ram_rdata)
    );

    // ---------------- outputs ----------------
    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = if_rv_q;
    assign d_rvalid  = d_rv_q;
    assign if_rdata  = (if_rv_q && !err_q)          ? w_ram_rdata : '0;
    assign d_rdata   = (d_rv_q && !we_q && !err_q)  ? w_ram_rdata : '0;

`ifdef MISALIGN_TRAP_EN
    assign if_err = if_rv_q && err_q;
    assign d_err  = d_rv_q  && err_q;
`else
    assign if_err = 1'b0;
    assign d_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_responder
//  Description : Directed self-checking bench. Three responders share the
//                request inputs: A (ADDR_W=10, LAT=1), B (ADDR_W=4, LAT=0),
//                C (ADDR_W=10, LAT=4). Each scenario observes only the
//                instance it targets. Honours MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic [2:0]  if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata [3];
    logic [31:0] d_rdata  [3];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_responder #(.ADDR_W(10), .LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .if_err(if_err[0]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0])
    );

    unified_mem_responder #(.ADDR_W(4), .LAT(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .if_err(if_err[1]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1])
    );

    unified_mem_responder #(.ADDR_W(10), .LAT(4)) u_dut_c (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[2]),
        .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]), .if_err(if_err[2]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[2]), .d_rvalid(d_rvalid[2]), .d_rdata(d_rdata[2]), .d_err(d_err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance k. lat is the cycle distance from
    // the grant cycle to the rvalid cycle (-1 if no response arrived).
    task automatic xact(input string tag, input int k, input bit is_d,
                        input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
        int  g;
        bit  seen;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (is_d ? d_gnt[k] : if_gnt[k]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
        g = cyc;
        @(posedge clk);
        #1;
        d_req  = 1'b0;
        if_req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (is_d ? d_rvalid[k] : if_rvalid[k]) begin
                rd  = is_d ? d_rdata[k] : if_rdata[k];
                er  = is_d ? d_err[k]   : if_err[k];
                lat = cyc - g;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          rv_seen;
        bit          gseen;

        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
        d_addr = 32'h100; if_addr = 32'h104; d_wdata = 32'h0;

        // Reset held with both ports requesting: nothing granted, outputs 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_ctl", {26'd0, d_gnt[0], if_gnt[0], d_rvalid[0], if_rvalid[0],
                              d_err[0], if_err[0]}, 32'd0);
            check("rst_rdata", d_rdata[0] | if_rdata[0], 32'd0);
        end

        // Release with both requesting: D, IF, D, IF ... every LAT+2 = 3 cycles.
        // Vector {d_gnt, if_gnt, d_rvalid, if_rvalid}.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("contend", {28'd0, d_gnt[0], if_gnt[0], d_rvalid[0], if_rvalid[0]},
                  {28'd0, (i % 6) == 0, (i % 6) == 3, (i % 6) == 2, (i % 6) == 5});
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // Store / load on A (LAT=1).
        xact("st1", 0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, rd, er, lat);
        check("st1_lat", 32'(lat), 32'd2);
        check("st1_rdata", rd, 32'd0);
        check("st1_err", {31'd0, er}, 32'd0);
        xact("ld1", 0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, rd, er, lat);
        check("ld1_lat", 32'(lat), 32'd2);
        check("ld1_rdata", rd, 32'hDEADBEEF);
        xact("st2", 0, 1'b1, 1'b1, 4'h1, 32'h40, 32'h000000AA, rd, er, lat);
        check("st2_lat", 32'(lat), 32'd2);
        xact("ld2", 0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, rd, er, lat);
        check("ld2_rdata", rd, 32'hDEADBEAA);
        // be = 0 store completes but leaves the word untouched.
        xact("st0", 0, 1'b1, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, rd, er, lat);
        check("st0_lat", 32'(lat), 32'd2);
        xact("ld3", 0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, rd, er, lat);
        check("ld3_rdata", rd, 32'hDEADBEAA);
        // Fetch sees the stored data.
        xact("if1", 0, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, rd, er, lat);
        check("if1_lat", 32'(lat), 32'd2);
        check("if1_rdata", rd, 32'hDEADBEAA);
        check("if1_err", {31'd0, er}, 32'd0);
        // Bit 12 lies above the index field and is ignored.
        xact("alias", 0, 1'b1, 1'b0, 4'hF, 32'h1040, 32'h0, rd, er, lat);
        check("alias_rdata", rd, 32'hDEADBEAA);
        // Misaligned load.
        xact("mis", 0, 1'b1, 1'b0, 4'hF, 32'h42, 32'h0, rd, er, lat);
        check("mis_lat", 32'(lat), 32'd2);
`ifdef MISALIGN_TRAP_EN
        check("mis_rdata", rd, 32'd0);
        check("mis_err", {31'd0, er}, 32'd1);
`else
        check("mis_rdata", rd, 32'hDEADBEAA);
        check("mis_err", {31'd0, er}, 32'd0);
`endif

        // B: 16-word array, LAT=0. 0x40 is word 16 -> aliases word 0.
        xact("b_st", 1, 1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, rd, er, lat);
        check("b_st_lat", 32'(lat), 32'd1);
        xact("b_if", 1, 1'b0, 1'b0, 4'h0, 32'h00, 32'h0, rd, er, lat);
        check("b_if_lat", 32'(lat), 32'd1);
        check("b_if_rdata", rd, 32'hCAFEF00D);

        // C: LAT=4, reset during WAIT drops the store.
        xact("c_st", 2, 1'b1, 1'b1, 4'hF, 32'h80, 32'h11111111, rd, er, lat);
        check("c_st_lat", 32'(lat), 32'd5);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'h22222222;
        gseen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (d_gnt[2]) begin
                gseen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("c_rst_gnt", {31'd0, gseen}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        rv_seen = 1'b0;
        @(negedge clk);                       // cycle 1
        if (d_rvalid[2]) rv_seen = 1'b1;
        @(negedge clk);                       // cycle 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (d_rvalid[2]) rv_seen = 1'b1;
        end
        check("c_no_rvalid", {31'd0, rv_seen}, 32'd0);
        xact("c_ld", 2, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, rd, er, lat);
        check("c_ld_lat", 32'(lat), 32'd5);
        check("c_ld_rdata", rd, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
